// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI master among N_REQ requesters
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req             per-requester level request, held until that requester's done
//   tx_data         packed transmit words, requester i at [i*DW +: DW]
//   gnt             one-hot owner, high from grant through the done cycle
//   sel             index of current (or most recent) owner
//   done            one-cycle completion pulse to the owner
//   err             one-cycle pulse alongside done when the transfer timed out
//   rx_data         last word captured from the SPI master
//   spi_start       one-cycle start pulse to the SPI master
//   spi_tx          word presented to the SPI master, latched at grant
//   spi_done        one-cycle end-of-transfer pulse from the SPI master
//   spi_rx          receive word from the SPI master, valid with spi_done
module spi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DW-1:0]        tx_data,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   sel,
    output logic [N_REQ-1:0]           done,
    output logic                       err,
    output logic [DW-1:0]              rx_data,
    output logic                       spi_start,
    output logic [DW-1:0]              spi_tx,
    input  logic                       spi_done,
    input  logic [DW-1:0]              spi_rx
);
    localparam int SW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [SW-1:0]     last_q, last_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rx_q, rx_d;
    logic              start_q, start_d;
    logic [DW-1:0]     spi_tx_q, spi_tx_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              win_found;
    logic [SW-1:0]     win_idx;
    int                cand;

    // Round-robin search starting just after the last owner and wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_q) + k) % N_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = SW'(cand);
            end
        end
    end

    // Outputs are registered on the transition into the state that owns them,
    // so spi_start appears the cycle after gnt and done/err the cycle after spi_done.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        done_d   = '0;
        err_d    = 1'b0;
        rx_d     = rx_q;
        start_d  = 1'b0;
        spi_tx_d = spi_tx_q;
        timer_d  = timer_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    gnt_d    = N_REQ'(1) << win_idx;
                    sel_d    = win_idx;
                    spi_tx_d = tx_data[win_idx*DW +: DW];
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A completion on the final allowed cycle beats the timeout.
                if (spi_done) begin
                    rx_d    = spi_rx;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = sel_q;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            last_q   <= SW'(N_REQ - 1);
            done_q   <= '0;
            err_q    <= 1'b0;
            rx_q     <= '0;
            start_q  <= 1'b0;
            spi_tx_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rx_q     <= rx_d;
            start_q  <= start_d;
            spi_tx_q <= spi_tx_d;
            timer_q  <= timer_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rx_data   = rx_q;
    assign spi_start = start_q;
    assign spi_tx    = spi_tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking bench for spi_arbiter
module tb_spi_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] tx_data;
    logic [N-1:0]   gnt;
    logic [1:0]     sel;
    logic [N-1:0]   done;
    logic           err;
    logic [W-1:0]   rx_data;
    logic           spi_start;
    logic [W-1:0]   spi_tx;
    logic           spi_done;
    logic [W-1:0]   spi_rx;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: owner history, last captured word, per-requester tx words.
    int          last_m;
    logic [7:0]  rx_m;
    logic [7:0]  txw [N];

    typedef struct {
        logic [3:0] r;
        int         d;
        logic [7:0] rxw;
        logic [3:0] eg;
        logic       ee;
        logic [7:0] erx;
        logic [7:0] etx;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    spi_arbiter #(.N_REQ(N), .DW(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .tx_data(tx_data),
        .gnt(gnt), .sel(sel), .done(done), .err(err), .rx_data(rx_data),
        .spi_start(spi_start), .spi_tx(spi_tx),
        .spi_done(spi_done), .spi_rx(spi_rx)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tx();
        for (int i = 0; i < N; i++) tx_data[i*W +: W] = txw[i];
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last_m + k) % N]) return (last_m + k) % N;
        end
        return -1;
    endfunction

    // One complete transaction. d = WAIT-relative sample at which spi_done is driven
    // (d outside 1..TO-1 means the transfer must time out).
    task automatic xfer(input string tag, input logic [3:0] r, input int d,
                        input logic [7:0] rxw, input bit drop,
                        output logic [3:0] og, output logic oe, output logic [7:0] orx,
                        output logic [7:0] otx);
        int         w, gw, done_at, nstart, exp_at;
        bit         stable, completes;
        logic [3:0] dn;
        logic [7:0] stx;
        og = '0; oe = 1'b0; orx = '0; otx = '0;
        req = r;
        set_tx();
        w = pick(r);
        gw = 0;
        while (gnt == '0 && gw < 8) begin
            step();
            gw++;
        end
        chk($sformatf("%s grant_latency", tag), gw, 1);
        if (gnt == '0) return;
        og  = gnt;
        otx = spi_tx;
        chk($sformatf("%s gnt", tag), gnt, 32'(1) << w);
        chk($sformatf("%s sel", tag), sel, w);
        chk($sformatf("%s spi_tx", tag), spi_tx, txw[w]);
        if (drop) req = '0;
        tx_data = $urandom;
        step();
        chk($sformatf("%s spi_start_latency", tag), spi_start, 1);
        nstart  = spi_start ? 1 : 0;
        done_at = -1;
        stable  = 1'b1;
        dn = '0; stx = '0;
        for (int c = 1; c <= TO + 3; c++) begin
            step();
            spi_done = 1'b0;
            if (spi_start) nstart++;
            if (gnt !== og) stable = 1'b0;
            if (done != '0) begin
                done_at = c;
                dn  = done;
                oe  = err;
                orx = rx_data;
                stx = spi_tx;
                break;
            end
            if (c == d) begin
                spi_done = 1'b1;
                spi_rx   = rxw;
            end
        end
        completes = (d >= 1 && d <= TO - 1);
        exp_at    = completes ? d + 1 : TO;
        if (completes) rx_m = rxw;
        chk($sformatf("%s done_cycle", tag), done_at, exp_at);
        chk($sformatf("%s done", tag), dn, 32'(1) << w);
        chk($sformatf("%s err", tag), oe, !completes);
        chk($sformatf("%s rx_data", tag), orx, rx_m);
        chk($sformatf("%s spi_tx_held", tag), stx, txw[w]);
        chk($sformatf("%s gnt_stable", tag), stable, 1);
        step();
        chk($sformatf("%s start_count", tag), nstart, 1);
        chk($sformatf("%s idle_gnt", tag), gnt, 0);
        chk($sformatf("%s idle_done", tag), done, 0);
        last_m = w;
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s gnt", tag), gnt, 0);
        chk($sformatf("%s done", tag), done, 0);
        chk($sformatf("%s err", tag), err, 0);
        chk($sformatf("%s spi_start", tag), spi_start, 0);
        chk($sformatf("%s spi_tx", tag), spi_tx, 0);
        chk($sformatf("%s rx_data", tag), rx_data, 0);
        chk($sformatf("%s sel", tag), sel, 0);
    endtask

    initial begin
        logic [3:0] og;
        logic       oe;
        logic [7:0] orx, otx;
        int         n;

        tbl[0]  = '{4'b0001, 10,  8'h55, 4'b0001, 1'b0, 8'h55, 8'hAA};
        tbl[1]  = '{4'b1111, 3,   8'h01, 4'b0010, 1'b0, 8'h01, 8'h11};
        tbl[2]  = '{4'b1111, 4,   8'h02, 4'b0100, 1'b0, 8'h02, 8'h22};
        tbl[3]  = '{4'b1111, 5,   8'h03, 4'b1000, 1'b0, 8'h03, 8'h33};
        tbl[4]  = '{4'b1111, 6,   8'h04, 4'b0001, 1'b0, 8'h04, 8'hAA};
        tbl[5]  = '{4'b1111, 2,   8'h05, 4'b0010, 1'b0, 8'h05, 8'h11};
        tbl[6]  = '{4'b0110, 7,   8'h06, 4'b0100, 1'b0, 8'h06, 8'h22};
        tbl[7]  = '{4'b0110, 1,   8'h07, 4'b0010, 1'b0, 8'h07, 8'h11};
        tbl[8]  = '{4'b1000, 0,   8'hEE, 4'b1000, 1'b1, 8'h07, 8'h33};
        tbl[9]  = '{4'b0001, 19,  8'h5A, 4'b0001, 1'b0, 8'h5A, 8'hAA};
        tbl[10] = '{4'b0100, 20,  8'h99, 4'b0100, 1'b1, 8'h5A, 8'h22};

        txw[0] = 8'hAA; txw[1] = 8'h11; txw[2] = 8'h22; txw[3] = 8'h33;
        req = '0; spi_done = 1'b0; spi_rx = '0;
        set_tx();
        rst = 1'b0;
        last_m = N - 1;
        rx_m   = '0;
        #1;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b1;

        foreach (tbl[i]) begin
            xfer($sformatf("vec%0d", i), tbl[i].r, tbl[i].d, tbl[i].rxw, 1'b0, og, oe, orx, otx);
            chk($sformatf("vec%0d table_gnt", i), og, tbl[i].eg);
            chk($sformatf("vec%0d table_err", i), oe, tbl[i].ee);
            chk($sformatf("vec%0d table_rx", i), orx, tbl[i].erx);
            chk($sformatf("vec%0d table_tx", i), otx, tbl[i].etx);
        end

        // spi_done while idle must be ignored.
        req = '0;
        step();
        spi_rx   = 8'hC3;
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        chk("idle_spi_done done", done, 0);
        chk("idle_spi_done rx_data", rx_data, rx_m);
        chk("idle_spi_done gnt", gnt, 0);
        step();
        chk("idle_spi_done start", spi_start, 0);
        chk("idle_spi_done gnt2", gnt, 0);

        // Reset asserted during WAIT: asynchronous clear, then requester 0 priority again.
        req = 4'b1111;
        n = 0;
        while (!spi_start && n < 10) begin
            step();
            n++;
        end
        chk("rst_mid reached_wait", spi_start, 1);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid async");
        step();
        chk_all_zero("rst_mid held");
        rst = 1'b1;
        last_m = N - 1;
        rx_m   = '0;
        req    = '0;
        xfer("post_rst", 4'b1010, 5, 8'h3C, 1'b0, og, oe, orx, otx);
        chk("post_rst first_gnt", og, 4'b0010);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            logic [3:0] r;
            int         d;
            r = 4'($urandom_range(1, 15));
            d = $urandom_range(0, TO + 1);
            for (int i = 0; i < N; i++) txw[i] = 8'($urandom);
            xfer($sformatf("rnd%0d", it), r, d, 8'($urandom), bit'($urandom_range(0, 1)),
                 og, oe, orx, otx);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one SPI master.
REQ-002 Parameter DW, default 8: SPI transfer width in bits.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester transfer request, level, held until own done.
REQ-007 tx_data  input  N_REQ*DW  packed; requester i at [i*DW +: DW].
REQ-008 gnt  output  N_REQ  one-hot ownership, high from grant through done cycle.
REQ-009 sel  output  clog2(N_REQ)  index of current or last owner.
REQ-010 done  output  N_REQ  one-cycle completion pulse to owner.
REQ-011 err  output  1  one-cycle pulse coincident with done on timeout.
REQ-012 rx_data  output  DW  last captured receive word.
REQ-013 spi_start  output  1  one-cycle start pulse to SPI master.
REQ-014 spi_tx  output  DW  word presented to SPI master, stable from START to DONE.
REQ-015 spi_done  input  1  one-cycle end-of-transfer pulse from SPI master.
REQ-016 spi_rx  input  DW  master receive word, valid when spi_done=1.

Function
REQ-017 FSM states IDLE, START, WAIT, DONE; one state per cycle except WAIT.
REQ-018 IDLE: any req bit high -> pick winner round-robin, search from last_owner+1 mod N_REQ upward; register gnt, sel, spi_tx=winner's tx_data; go START.
REQ-019 IDLE, no req -> remain IDLE, gnt=0.
REQ-020 START: spi_start=1 for exactly this cycle; clear timer; go WAIT.
REQ-021 WAIT, spi_done=1 -> rx_data<=spi_rx; go DONE with err flag clear.
REQ-022 WAIT, timer reaches TIMEOUT without spi_done -> go DONE with err flag set; rx_data unchanged.
REQ-023 Timer increments once per WAIT cycle; spi_done on the same cycle as timeout wins (normal completion).
REQ-024 DONE: done[sel]=1 and err=flag for one cycle; last_owner<=sel; go IDLE; gnt clears on exit.
REQ-025 Latency: req seen in IDLE -> gnt next cycle; spi_start one cycle after gnt; done one cycle after spi_done.
REQ-026 Back-to-back: after DONE, IDLE cycle always occurs before next grant.
REQ-027 Owner dropping req mid-transfer: transfer completes, done still pulses.
REQ-028 tx_data changes after grant do not affect spi_tx.
REQ-029 spi_done in IDLE, START or DONE ignored; no done, no rx_data update.
REQ-030 rx_data holds value until next capture; sel holds after DONE.

Reset
REQ-031 rst low -> immediately: state IDLE, gnt=0, done=0, err=0, spi_start=0, spi_tx=0, rx_data=0, sel=0, timer=0.
REQ-032 Reset sets last_owner=N_REQ-1 so requester 0 has first priority.
REQ-033 Reset mid-transfer aborts without done pulse; in-flight SPI result discarded.

Verification
REQ-034 req=0001, tx_data[0]=8'hAA, model returns 8'h55 via spi_done 10 cycles after start -> one spi_start, spi_tx=AA, gnt=0001 throughout, done=0001 one cycle, rx_data=55, err=0.
REQ-035 req=1111 held, model completes each -> grant order 0,1,2,3,0; one IDLE cycle between each done and next gnt.
REQ-036 After owner 1 completes, req=0110 -> gnt=0100; then gnt=0010 next.
REQ-037 spi_done never asserted -> after TIMEOUT WAIT cycles done[owner]=1 and err=1 same cycle; rx_data unchanged.
REQ-038 rst low during WAIT -> all outputs 0 asynchronously; after release req=1010 -> gnt=0010 first.
REQ-039 spi_done pulsed in IDLE with req=0 -> no done, rx_data unchanged, state IDLE.
